// File: rtl/capture_pkg.sv
// capture_pkg: shared types and constants for the multi-channel capture buffer.
//   state_e        capture FSM states
//   NCH_C          channels per frame (fixed at 4)
//   DW_DEFAULT     default sample width
//   DEPTH_DEFAULT  default RAM depth in words
package capture_pkg;

    localparam int unsigned NCH_C         = 4;
    localparam int unsigned DW_DEFAULT    = 8;
    localparam int unsigned DEPTH_DEFAULT = 4096;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StWrite,
        StDone
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// capture_ram: single-port synchronous RAM, DEPTH x DW, registered read.
// Written behaviourally so it maps onto block RAM. Contents are not reset.
//   clk_i    clock
//   we_i     write enable; wdata_i is stored at addr_i
//   re_i     read enable; mem[addr_i] appears on rdata_o next cycle
//   addr_i   shared read/write address
//   wdata_i  write data
//   rdata_o  registered read data (holds its value while re_i is low)
module capture_ram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4096,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_buffer.sv
// capture_buffer: armed, one-shot, all-channel capture of ADC sampler frames.
// Each rising edge of new_sample (while armed and waiting) latches ch0..ch3 and
// writes them to RAM over four cycles, interleaved (word 4f+c = channel c of
// frame f). When DEPTH words are written the capture is held and read out one
// word per rd_req with one cycle of latency.
//   clk, reset        clock and synchronous active-high reset
//   arm               pulse: start a capture (ignored while busy; restarts from DONE)
//   new_sample        sampler strobe level; rising edge = fresh frame
//   ch0..ch3          channel samples, stable while new_sample is high
//   busy              high in WAIT or WRITE
//   done              high in DONE
//   overrun           sticky: a frame edge arrived during WRITE and was dropped
//   rd_req            read request, honoured only in DONE
//   rd_data/rd_valid  read data and its one-cycle qualifier
module capture_buffer
    import capture_pkg::*;
#(
    parameter int unsigned DW    = DW_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          new_sample,
    input  logic [DW-1:0] ch0,
    input  logic [DW-1:0] ch1,
    input  logic [DW-1:0] ch2,
    input  logic [DW-1:0] ch3,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned SelW = $clog2(NCH_C);
    localparam logic [AW-1:0]   LastAddr = AW'(DEPTH - 1);
    localparam logic [SelW-1:0] LastChan = SelW'(NCH_C - 1);

    state_e state_q, state_d;

    logic                       prev_q;
    logic [NCH_C-1:0][DW-1:0]   hold_q, hold_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic                       overrun_q, overrun_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       rd_valid_q, rd_valid_d;

    logic                       sample_edge;
    logic [SelW-1:0]            wr_sel;
    logic                       ram_we;
    logic                       ram_re;
    logic [AW-1:0]              ram_addr;
    logic [DW-1:0]              ram_wdata;
    logic [DW-1:0]              ram_rdata;

    assign sample_edge = new_sample & ~prev_q;

    // Frames always start on a multiple of NCH_C, so the low pointer bits give
    // the channel being written in the current WRITE cycle.
    assign wr_sel = wr_ptr_q[SelW-1:0];

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overrun_d  = overrun_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_wdata  = hold_q[wr_sel];

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d   = StWait;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    overrun_d = 1'b0;
                end
            end

            StWait: begin
                if (sample_edge) begin
                    hold_d  = {ch3, ch2, ch1, ch0};
                    state_d = StWrite;
                end
            end

            StWrite: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (sample_edge) begin
                    overrun_d = 1'b1;
                end
                if (wr_sel == LastChan) begin
                    // Last-word compare rather than ptr==0, so the full case
                    // is seen on the write itself.
                    state_d = (wr_ptr_q == LastAddr) ? StDone : StWait;
                end
            end

            StDone: begin
                if (arm) begin
                    state_d   = StWait;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    overrun_d = 1'b0;
                end else if (rd_req) begin
                    ram_re     = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    if (rd_ptr_q == LastAddr) begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered from next state so they line up with the state register.
        busy_d = (state_d == StWait) || (state_d == StWrite);
        done_d = (state_d == StDone);
    end

    // Writes only occur in WRITE and reads only in DONE, so one port suffices.
    assign ram_addr = (state_q == StWrite) ? wr_ptr_q : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            prev_q     <= 1'b1;  // a strobe already high at release is not an edge
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= new_sample;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    capture_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // RAM output register is not reset; gate it so rd_data is zero when idle.
    assign rd_data  = rd_valid_q ? ram_rdata : '0;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_capture_buffer.sv
module tb_capture_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          new_sample = 1'b0;
    logic [DW-1:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
    logic          busy, done, overrun;
    logic          rd_req = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: what the capture should contain and what the flags should be.
    logic [7:0] m_mem [DEPTH];
    int         m_wr, m_rd, m_last;
    bit         m_cap, m_done, m_ovr;

    capture_buffer #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .new_sample (new_sample),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_wr = 0; m_rd = 0; m_last = -100;
        m_cap = 0; m_done = 0; m_ovr = 0;
    endfunction

    function automatic void m_arm();
        m_wr = 0; m_rd = 0; m_last = -100;
        m_cap = 1; m_done = 0; m_ovr = 0;
    endfunction

    // A frame edge at cycle e: dropped with overrun if within 5 cycles of the last
    // accepted edge, otherwise stored if a capture is armed and not yet full.
    function automatic void m_edge(input int e, input logic [31:0] f);
        if (e - m_last > 0 && e - m_last < 5) begin
            m_ovr = 1;
        end else if (m_cap) begin
            for (int c = 0; c < 4; c++) m_mem[m_wr + c] = f[8*c +: 8];
            m_wr  += 4;
            m_last = e;
            if (m_wr == DEPTH) begin
                m_cap  = 0;
                m_done = 1;
            end
        end
    endfunction

    task automatic strobe(input logic [31:0] f, input int gap);
        {ch3, ch2, ch1, ch0} = f;
        new_sample = 1'b1;
        m_edge(cyc, f);
        tick();
        new_sample = 1'b0;
        tick();
        repeat (gap) tick();
    endtask

    task automatic status(input string tag);
        chk({tag, ".busy"}, busy, m_cap);
        chk({tag, ".done"}, done, m_done);
        chk({tag, ".overrun"}, overrun, m_ovr);
    endtask

    task automatic read_words(input int n);
        rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == n - 1) rd_req = 1'b0;
            chk("rd_valid", rd_valid, 1);
            chk("rd_data", rd_data, m_mem[m_rd]);
            m_rd++;
            if (m_rd == DEPTH) m_done = 0;
            chk("rd.done", done, m_done);
        end
        tick();
        chk("rd_valid_after", rd_valid, 0);
    endtask

    task automatic capture_random();
        for (int f = 0; f < 4; f++) strobe($urandom, $urandom_range(3, 6));
    endtask

    initial begin
        m_reset();
        reset = 1'b1;
        repeat (3) tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.overrun", overrun, 0);
        chk("rst.rd_valid", rd_valid, 0);
        chk("rst.rd_data", rd_data, 0);
        reset = 1'b0;
        tick();

        // Basic capture with a fixed pattern and exact done timing.
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        chk("arm.busy", busy, 1);
        for (int f = 0; f < 3; f++) begin
            strobe({8'(f*16+3), 8'(f*16+2), 8'(f*16+1), 8'(f*16)}, 3);
            status("frame");
        end
        strobe({8'h33, 8'h32, 8'h31, 8'h30}, 0);  // now edge+2
        chk("e2.done", done, 0);
        tick();
        chk("e3.done", done, 0);
        tick();
        chk("e4.done", done, 0);
        chk("e4.busy", busy, 1);
        tick();
        chk("e5.done", done, 1);
        chk("e5.busy", busy, 0);
        read_words(DEPTH);
        status("idle1");

        // Strobes and reads without arm, then reads while waiting.
        strobe($urandom, 3);
        strobe($urandom, 3);
        status("noarm");
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle.rd_valid", rd_valid, 0);
        end
        rd_req = 1'b0;
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait.rd_valid", rd_valid, 0);
            chk("wait.busy", busy, 1);
        end
        rd_req = 1'b0;

        // Overrun: second strobe 2 cycles after an accepted edge.
        strobe($urandom, 0);
        strobe($urandom, 1);
        chk("ovr.flag", overrun, 1);
        strobe($urandom, 3);
        strobe($urandom, 3);
        strobe($urandom, 3);
        status("ovr.full");

        // Partial readout, then re-arm from DONE.
        read_words(5);
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        status("rearm");
        capture_random();
        status("rearm.full");
        read_words(DEPTH);

        // Strobe held high across reset release must not count as an edge.
        new_sample = 1'b1;
        {ch3, ch2, ch1, ch0} = $urandom;
        reset = 1'b1; m_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        repeat (4) tick();
        status("held");
        new_sample = 1'b0;
        tick();
        capture_random();
        status("held.full");
        read_words(DEPTH);

        // Reset in the second WRITE cycle.
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        {ch3, ch2, ch1, ch0} = $urandom;
        new_sample = 1'b1;
        tick();
        new_sample = 1'b0;
        tick();
        reset = 1'b1; m_reset();
        tick();
        status("midrst");
        chk("midrst.rd_valid", rd_valid, 0);
        chk("midrst.rd_data", rd_data, 0);
        reset = 1'b0;
        tick();
        arm = 1'b1; m_arm(); tick(); arm = 1'b0;
        capture_random();
        status("post.full");
        read_words(DEPTH);
        status("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
